// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter and line/burst adaptor between NUM_CH
// cache channels and a single burst-based physical memory port.
//   clk, rst        : rising-edge clock, asynchronous active-low reset
//   ch_read/write   : per-channel line requests, held until ch_resp
//   ch_address      : per-channel byte address (32 bits per channel)
//   ch_wdata        : per-channel write line (LINE_WIDTH bits per channel)
//   ch_rdata        : shared read line buffer
//   ch_resp         : one-hot completion pulse
//   pmem_read/write : burst strobes
//   pmem_address    : line-aligned burst address
//   pmem_wdata      : current write beat
//   pmem_resp       : one pulse per completed beat
//   pmem_rdata      : read beat, valid with pmem_resp
module pmem_arbiter #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BUS_WIDTH  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_read,
  input  logic [NUM_CH-1:0]            ch_write,
  input  logic [NUM_CH*32-1:0]         ch_address,
  input  logic [NUM_CH*LINE_WIDTH-1:0] ch_wdata,
  output logic [LINE_WIDTH-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]            ch_resp,
  output logic                         pmem_read,
  output logic                         pmem_write,
  output logic [31:0]                  pmem_address,
  output logic [BUS_WIDTH-1:0]         pmem_wdata,
  input  logic                         pmem_resp,
  input  logic [BUS_WIDTH-1:0]         pmem_rdata
);

  localparam int unsigned BEATS  = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned OFFS   = $clog2(LINE_WIDTH / 8);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFFS) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [PW-1:0]    LAST_CH   = PW'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t                  state;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           gnt;
  logic [CNT_W-1:0]        beat;
  logic [LINE_WIDTH-1:0]   wline_q;

  logic [NUM_CH-1:0]       req_c;
  logic                    req_any_c;
  logic [PW-1:0]           win_c;
  logic [PW-1:0]           idx_c;
  logic [LINE_WIDTH-1:0]   win_line_c;
  logic [31:0]             win_addr_c;

  assign req_c = ch_read | ch_write;

  // Round-robin scan starting at ptr; first requesting channel wins.
  always_comb begin
    req_any_c = 1'b0;
    win_c     = '0;
    idx_c     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx_c = PW'((32'(ptr) + i) % NUM_CH);
      if (!req_any_c && req_c[idx_c]) begin
        req_any_c = 1'b1;
        win_c     = idx_c;
      end
    end
  end

  assign win_line_c = ch_wdata[32'(win_c)*LINE_WIDTH +: LINE_WIDTH];
  assign win_addr_c = ch_address[32'(win_c)*32 +: 32] & ALIGN_MASK;

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt          <= '0;
      beat         <= '0;
      wline_q      <= '0;
      ch_rdata     <= '0;
      ch_resp      <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      ch_resp <= '0;
      unique case (state)
        IDLE: begin
          if (req_any_c) begin
            gnt          <= win_c;
            beat         <= '0;
            pmem_address <= win_addr_c;
            wline_q      <= win_line_c;
            pmem_wdata   <= win_line_c[BUS_WIDTH-1:0];
            // Write takes priority when both requests are raised.
            pmem_write   <= ch_write[win_c];
            pmem_read    <= ~ch_write[win_c];
            state        <= BURST;
          end
        end
        BURST: begin
          if (pmem_resp) begin
            if (!pmem_write) begin
              ch_rdata[32'(beat)*BUS_WIDTH +: BUS_WIDTH] <= pmem_rdata;
            end
            if (beat == LAST_BEAT) begin
              pmem_read  <= 1'b0;
              pmem_write <= 1'b0;
              ch_resp    <= NUM_CH'(1) << gnt;
              state      <= DONE;
            end else begin
              beat       <= beat + CNT_W'(1);
              pmem_wdata <= wline_q[(32'(beat) + 32'd1)*BUS_WIDTH +: BUS_WIDTH];
            end
          end
        end
        DONE: begin
          ptr   <= (gnt == LAST_CH) ? '0 : gnt + PW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: 2-channel instance with a configurable
// wait-state memory responder, plus a 4-channel instance for grant order.
module tb_pmem_arbiter;

  localparam int unsigned LW = 256;
  localparam int unsigned BW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-channel instance
  logic [1:0]      ch_read, ch_write, ch_resp;
  logic [63:0]     ch_address;
  logic [2*LW-1:0] ch_wdata;
  logic [LW-1:0]   ch_rdata;
  logic            pmem_read, pmem_write, pmem_resp;
  logic [31:0]     pmem_address;
  logic [BW-1:0]   pmem_wdata, pmem_rdata;

  // 4-channel instance
  logic [3:0]      ch_read4, ch_write4, ch_resp4;
  logic [127:0]    ch_address4;
  logic [4*LW-1:0] ch_wdata4;
  logic [LW-1:0]   ch_rdata4;
  logic            pmem_read4, pmem_write4, pmem_resp4;
  logic [31:0]     pmem_address4;
  logic [BW-1:0]   pmem_wdata4, pmem_rdata4;

  pmem_arbiter #(.NUM_CH(2), .LINE_WIDTH(LW), .BUS_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata),
    .ch_resp(ch_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  pmem_arbiter #(.NUM_CH(4), .LINE_WIDTH(LW), .BUS_WIDTH(BW)) dut4 (
    .clk(clk), .rst(rst), .ch_read(ch_read4), .ch_write(ch_write4),
    .ch_address(ch_address4), .ch_wdata(ch_wdata4), .ch_rdata(ch_rdata4),
    .ch_resp(ch_resp4), .pmem_read(pmem_read4), .pmem_write(pmem_write4),
    .pmem_address(pmem_address4), .pmem_wdata(pmem_wdata4),
    .pmem_resp(pmem_resp4), .pmem_rdata(pmem_rdata4)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]    resp;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  logic [BW-1:0] wq[$];
  logic [LW-1:0] model_rdata;
  logic [BW-1:0] fixed_beat [4];
  bit            fixed_beats = 1'b1;
  bit            idle_pulse  = 1'b0;
  int            wait_n      = 0;
  logic [31:0]   burst_addr  = '0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] gen_beat(input logic [31:0] a, input int k);
    return {a, 24'hC0FFEE, 8'(k)};
  endfunction

  function automatic logic [LW-1:0] gen_line(input logic [31:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < 4; k++) l[k*BW +: BW] = gen_beat(a, k);
    return l;
  endfunction

  // Memory model for the 2-channel instance: wait_n idle cycles before
  // each beat; checks strobe/address/wdata stability across wait cycles.
  initial begin
    int cnt, bk;
    logic prev_act, prev_resp;
    logic [BW-1:0] prev_wd;
    logic [31:0] prev_ad;
    cnt = 0; bk = 0; prev_act = 1'b0; prev_resp = 1'b0;
    prev_wd = '0; prev_ad = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cnt = 0; bk = 0; prev_act = 1'b0; pmem_resp = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if (prev_act && !prev_resp) begin
          check("wait_wdata_stable", LW'(pmem_wdata), LW'(prev_wd));
          check("wait_addr_stable", LW'(pmem_address), LW'(prev_ad));
        end
        if (bk == 0 && cnt == 0) burst_addr = pmem_address;
        if (cnt == wait_n) begin
          pmem_resp  = 1'b1;
          pmem_rdata = fixed_beats ? fixed_beat[bk % 4] : gen_beat(pmem_address, bk);
          if (pmem_write) wq.push_back(pmem_wdata);
          bk++; cnt = 0;
        end else begin
          pmem_resp = 1'b0;
          cnt++;
        end
        prev_act = 1'b1; prev_resp = pmem_resp;
        prev_wd = pmem_wdata; prev_ad = pmem_address;
      end else begin
        pmem_resp = idle_pulse;
        pmem_rdata = '0;
        cnt = 0; bk = 0; prev_act = 1'b0;
      end
    end
  end

  // Zero-wait memory for the 4-channel instance.
  initial begin
    pmem_resp4 = 1'b0; pmem_rdata4 = '0;
    forever begin
      @(negedge clk);
      pmem_resp4 = pmem_read4 | pmem_write4;
    end
  end

  task automatic wait_resp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ch_resp == 2'b00 && cyc < 100);
  endtask

  task automatic expect_resp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      e.resp = 2'b00; e.rdata = 'x;
    end else begin
      e = sb.pop_front();
    end
    check({tag, "_resp"}, LW'(ch_resp), LW'(e.resp));
    check({tag, "_rdata"}, ch_rdata, e.rdata);
  endtask

  initial begin
    int cyc;
    logic [LW-1:0] wline;
    logic [BW-1:0] v;
    logic [1:0] seen;
    int q4[$];

    rst = 1'b1;
    ch_read = '0; ch_write = '0; ch_address = '0; ch_wdata = '0;
    ch_read4 = '0; ch_write4 = '0; ch_address4 = '0; ch_wdata4 = '0;
    model_rdata = '0;
    fixed_beat[0] = {16{4'h1}}; fixed_beat[1] = {16{4'h2}};
    fixed_beat[2] = {16{4'h3}}; fixed_beat[3] = {16{4'h4}};
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pmem_read", LW'(pmem_read), LW'(1'b0));
    check("rst_pmem_write", LW'(pmem_write), LW'(1'b0));
    check("rst_ch_resp", LW'(ch_resp), LW'(2'b00));
    check("rst_ch_rdata", ch_rdata, '0);
    check("rst_pmem_address", LW'(pmem_address), LW'(32'h0));
    check("rst_pmem_wdata", LW'(pmem_wdata), LW'(64'h0));
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait read on ch0
    wait_n = 0; fixed_beats = 1'b1;
    ch_address[31:0] = 32'h0000_1234;
    ch_read[0] = 1'b1;
    model_rdata = {fixed_beat[3], fixed_beat[2], fixed_beat[1], fixed_beat[0]};
    sb.push_back('{2'b01, model_rdata});
    wait_resp(cyc);
    check("t1_cycle", LW'(cyc), LW'(5));
    check("t1_addr", LW'(burst_addr), LW'(32'h0000_1220));
    expect_resp("t1");
    ch_read = '0;
    @(negedge clk);

    // Write on ch1 with two wait cycles per beat
    wait_n = 2;
    ch_address[63:32] = 32'h0000_805F;
    wline = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
             64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    ch_wdata[2*LW-1:LW] = wline;
    wq.delete();
    ch_write[1] = 1'b1;
    sb.push_back('{2'b10, model_rdata});
    wait_resp(cyc);
    check("t2_cycle", LW'(cyc), LW'(13));
    check("t2_addr", LW'(burst_addr), LW'(32'h0000_8040));
    expect_resp("t2");
    check("t2_nbeats", LW'(wq.size()), LW'(4));
    for (int k = 0; k < 4; k++) begin
      v = (k < wq.size()) ? wq[k] : 'x;
      check($sformatf("t2_wbeat%0d", k), LW'(v), LW'(wline[k*BW +: BW]));
    end
    ch_write = '0;
    wait_n = 0;
    @(negedge clk);

    // Simultaneous requests, twice, then ch1 held while ch0 re-requests
    fixed_beats = 1'b0;
    ch_address = {32'h0000_0200, 32'h0000_0100};
    for (int p = 0; p < 2; p++) begin
      ch_read = 2'b11;
      sb.push_back('{2'b01, gen_line(32'h100)});
      sb.push_back('{2'b10, gen_line(32'h200)});
      wait_resp(cyc);
      expect_resp($sformatf("t3_pair%0d_first", p));
      ch_read[0] = 1'b0;
      wait_resp(cyc);
      expect_resp($sformatf("t3_pair%0d_second", p));
      ch_read[1] = 1'b0;
      @(negedge clk);
    end
    ch_read = 2'b11;
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) sb.push_back('{2'b01, gen_line(32'h100)});
      else            sb.push_back('{2'b10, gen_line(32'h200)});
    end
    for (int n = 0; n < 4; n++) begin
      wait_resp(cyc);
      expect_resp($sformatf("t3_alt%0d", n));
      if (n % 2 == 0) begin
        ch_read[0] = 1'b0;
        @(negedge clk);
        ch_read[0] = 1'b1;
      end
    end
    ch_read = '0;
    model_rdata = gen_line(32'h200);
    @(negedge clk);

    // Reset in the third BURST cycle of a read
    ch_address[31:0] = 32'h0000_0300;
    ch_read[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_pre_read", LW'(pmem_read), LW'(1'b1));
    rst = 1'b0;
    #1;
    check("t4_read", LW'(pmem_read), LW'(1'b0));
    check("t4_write", LW'(pmem_write), LW'(1'b0));
    check("t4_resp", LW'(ch_resp), LW'(2'b00));
    check("t4_rdata", ch_rdata, '0);
    check("t4_addr", LW'(pmem_address), LW'(32'h0));
    ch_read = '0;
    model_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    seen = '0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | ch_resp | {pmem_read, pmem_write};
    end
    check("t4_no_activity", LW'(seen), LW'(2'b00));
    model_rdata = gen_line(32'h300);
    sb.push_back('{2'b01, model_rdata});
    ch_read[0] = 1'b1;
    wait_resp(cyc);
    check("t4_reissue_cycle", LW'(cyc), LW'(5));
    expect_resp("t4_reissue");
    ch_read = '0;
    @(negedge clk);

    // pmem_resp pulses in IDLE are ignored; read+write on ch0 is a write
    idle_pulse = 1'b1;
    seen = '0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | ch_resp | {pmem_read, pmem_write};
    end
    idle_pulse = 1'b0;
    check("t5_idle_pulses", LW'(seen), LW'(2'b00));
    ch_address[31:0] = 32'h0000_4000;
    wline = {64'h4444_5555_6666_7777, 64'h0123_4567_89AB_CDEF,
             64'hFEDC_BA98_7654_3210, 64'h1111_2222_3333_4444};
    ch_wdata[LW-1:0] = wline;
    wq.delete();
    ch_read[0] = 1'b1; ch_write[0] = 1'b1;
    sb.push_back('{2'b01, model_rdata});
    @(negedge clk);
    check("t5_pmem_write", LW'(pmem_write), LW'(1'b1));
    check("t5_pmem_read", LW'(pmem_read), LW'(1'b0));
    wait_resp(cyc);
    check("t5_cycle", LW'(cyc), LW'(4));
    expect_resp("t5");
    for (int k = 0; k < 4; k++) begin
      v = (k < wq.size()) ? wq[k] : 'x;
      check($sformatf("t5_wbeat%0d", k), LW'(v), LW'(wline[k*BW +: BW]));
    end
    ch_read = '0; ch_write = '0;
    @(negedge clk);

    // NUM_CH = 4, all channels requesting continuously
    ch_address4 = {32'h0000_0C00, 32'h0000_0800, 32'h0000_0400, 32'h0000_0000};
    q4 = '{0, 1, 2, 3, 0};
    ch_read4 = 4'hF;
    for (int n = 0; n < 5; n++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (ch_resp4 == 4'h0 && cyc < 50);
      check($sformatf("t6_grant%0d", n), LW'(ch_resp4), LW'(4'b0001 << q4.pop_front()));
    end
    ch_read4 = '0;
    repeat (2) @(negedge clk);

    check("sb_drained", LW'(sb.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
